// File: rtl/hist_eq_pkg.sv
// Shared types and default parameter values for the histogram-equalizer video path.
package hist_eq_pkg;

  // Frame scheduler states: waiting for enable, hunting for SOF, forwarding a frame.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    ACTIVE = 2'd2
  } sched_state_t;

  // Power-on parameter values, shared with hist_eq_module.
  localparam int HE_DATA_WIDTH   = 8;
  localparam int HE_DEF_CONTRAST = 170;
  localparam int HE_DEF_UPPER    = 250;
  localparam int HE_DEF_LOWER    = 100;
  localparam bit HE_DEF_THR_EN   = 1'b1;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hist_eq_geom_cnt.sv
// Column/row position tracker for the forwarded pixel stream, with end-of-line,
// end-of-frame and geometry-error decode. All decode outputs are qualified by beat.
module hist_eq_geom_cnt
  import hist_eq_pkg::*;
#(
  parameter int WIDTH  = 1280,
  parameter int HEIGHT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic beat,           // forwarded beat this cycle
  input  logic sof,            // tuser of the current beat
  input  logic tlast,          // tlast of the current beat
  input  logic active,         // scheduler is inside a frame
  output logic eof,            // this beat completes the frame
  output logic err_eol_early,  // tlast before the last column
  output logic err_eol_late,   // last column reached without tlast
  output logic err_sof_early   // SOF in the middle of a frame
);

  localparam int CW = cnt_width(WIDTH);
  localparam int RW = cnt_width(HEIGHT);
  localparam logic [CW-1:0] LAST_COL = CW'(WIDTH - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(HEIGHT - 1);

  logic [CW-1:0] col_q, col_d, eff_col;
  logic [RW-1:0] row_q, row_d, eff_row;
  logic          restart, last_col, eol;

  // Position of the current beat (a mid-frame SOF counts as col 0 of a new frame) and next position.
  // NOTE: every signal driven here gets a default first so no path can infer a latch.
  always_comb begin
    restart       = 1'b0;
    eff_col       = col_q;
    eff_row       = row_q;
    last_col      = 1'b0;
    eol           = 1'b0;
    eof           = 1'b0;
    err_eol_early = 1'b0;
    err_eol_late  = 1'b0;
    err_sof_early = 1'b0;
    col_d         = col_q;
    row_d         = row_q;
    if (beat) begin
      restart = sof && active && ((col_q != '0) || (row_q != '0));
      if (restart) begin
        eff_col = '0;
        eff_row = '0;
      end
      last_col      = (eff_col == LAST_COL);
      eol           = tlast || last_col;
      eof           = eol && (eff_row == LAST_ROW);
      err_eol_early = tlast && !last_col;
      err_eol_late  = !tlast && last_col;
      err_sof_early = restart;
      if (eof) begin
        col_d = '0;
        row_d = '0;
      end else if (eol) begin
        col_d = '0;
        row_d = eff_row + RW'(1);
      end else begin
        col_d = eff_col + CW'(1);
        row_d = eff_row;
      end
    end
  end

  // Position registers advance only on forwarded beats.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

endmodule

// File: rtl/hist_eq_frame_sched.sv
// Frame-level gate in front of hist_eq_module: forwards only whole frames starting at SOF,
// commits threshold/bound parameters on frame boundaries and reports frame/error status.
module hist_eq_frame_sched
  import hist_eq_pkg::*;
#(
  parameter int DATA_WIDTH   = HE_DATA_WIDTH,
  parameter int WIDTH        = 1280,
  parameter int HEIGHT       = 1024,
  parameter int DEF_CONTRAST = HE_DEF_CONTRAST,
  parameter int DEF_UPPER    = HE_DEF_UPPER,
  parameter int DEF_LOWER    = HE_DEF_LOWER,
  parameter bit DEF_THR_EN   = HE_DEF_THR_EN
) (
  input  logic                  i_sys_clk,
  input  logic                  i_sys_areset,
  input  logic                  cfg_enable,
  input  logic                  cfg_update,
  input  logic [DATA_WIDTH-1:0] cfg_contrast,
  input  logic [DATA_WIDTH-1:0] cfg_upper,
  input  logic [DATA_WIDTH-1:0] cfg_lower,
  input  logic                  cfg_thr_en,
  input  logic                  sts_clr,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tuser,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tuser,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] contrast_threshold_param,
  output logic [DATA_WIDTH-1:0] upper_bound_param,
  output logic [DATA_WIDTH-1:0] lower_bound_param,
  output logic                  thresholding_en,
  output logic                  sts_busy,
  output logic                  sts_cfg_pending,
  output logic                  sts_frame_done,
  output logic [31:0]           sts_frame_cnt,
  output logic                  sts_err_eol_early,
  output logic                  sts_err_eol_late,
  output logic                  sts_err_sof_early
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] contrast;
    logic [DATA_WIDTH-1:0] upper;
    logic [DATA_WIDTH-1:0] lower;
    logic                  thr_en;
  } param_t;

  localparam param_t PARAM_DEF = '{
    contrast: DATA_WIDTH'(DEF_CONTRAST),
    upper:    DATA_WIDTH'(DEF_UPPER),
    lower:    DATA_WIDTH'(DEF_LOWER),
    thr_en:   DEF_THR_EN
  };

  sched_state_t state_q, state_d;
  param_t       active_q, shadow_q, cfg_new;
  logic         pending_q;
  logic [31:0]  frame_cnt_q;
  logic [2:0]   err_q, err_ev;
  logic         pass, fwd, sof_beat, frame_end;
  logic         eof, ev_eol_early, ev_eol_late, ev_sof_early;

  // Combinational pass-through datapath; only the handshake is gated.
  assign pass          = (state_q == ACTIVE) || ((state_q == SYNC) && s_axis_tuser);
  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tuser  = s_axis_tuser;
  assign m_axis_tlast  = s_axis_tlast;
  assign m_axis_tvalid = s_axis_tvalid && pass;
  assign s_axis_tready = pass ? m_axis_tready : 1'b1;
  assign fwd           = s_axis_tvalid && pass && m_axis_tready;
  assign sof_beat      = fwd && s_axis_tuser;
  assign frame_end     = fwd && eof;
  assign cfg_new       = '{contrast: cfg_contrast, upper: cfg_upper,
                           lower: cfg_lower, thr_en: cfg_thr_en};

  hist_eq_geom_cnt #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_geom (
    .clk           (i_sys_clk),
    .rst           (i_sys_areset),
    .beat          (fwd),
    .sof           (s_axis_tuser),
    .tlast         (s_axis_tlast),
    .active        (state_q == ACTIVE),
    .eof           (eof),
    .err_eol_early (ev_eol_early),
    .err_eol_late  (ev_eol_late),
    .err_sof_early (ev_sof_early)
  );

  // Next-state logic: a started frame always runs to its end before enable is honoured.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (cfg_enable) state_d = SYNC;
      end
      SYNC: begin
        if (sof_beat)         state_d = frame_end ? (cfg_enable ? SYNC : IDLE) : ACTIVE;
        else if (!cfg_enable) state_d = IDLE;
      end
      ACTIVE: begin
        if (frame_end) state_d = cfg_enable ? SYNC : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_sys_clk or posedge i_sys_areset) begin
    if (i_sys_areset) state_q <= IDLE;
    else              state_q <= state_d;
  end

  // Shadow/active parameters: a same-cycle update on an SOF beat commits straight through.
  always_ff @(posedge i_sys_clk or posedge i_sys_areset) begin
    if (i_sys_areset) begin
      active_q  <= PARAM_DEF;
      shadow_q  <= PARAM_DEF;
      pending_q <= 1'b0;
    end else if (sof_beat) begin
      if (cfg_update) begin
        active_q <= cfg_new;
        shadow_q <= cfg_new;
      end else if (pending_q) begin
        active_q <= shadow_q;
      end
      pending_q <= 1'b0;
    end else if (cfg_update) begin
      shadow_q  <= cfg_new;
      pending_q <= 1'b1;
    end
  end

  // Frame counter and sticky error flags; a new error event wins over a clear.
  assign err_ev = {ev_sof_early, ev_eol_late, ev_eol_early};
  always_ff @(posedge i_sys_clk or posedge i_sys_areset) begin
    if (i_sys_areset) begin
      frame_cnt_q <= '0;
      err_q       <= '0;
    end else begin
      if (frame_end) frame_cnt_q <= frame_cnt_q + 32'd1;
      err_q <= (err_q & ~{3{sts_clr}}) | err_ev;
    end
  end

  assign contrast_threshold_param = active_q.contrast;
  assign upper_bound_param        = active_q.upper;
  assign lower_bound_param        = active_q.lower;
  assign thresholding_en          = active_q.thr_en;
  assign sts_busy                 = (state_q == ACTIVE);
  assign sts_cfg_pending          = pending_q;
  assign sts_frame_done           = frame_end;
  assign sts_frame_cnt            = frame_cnt_q;
  assign sts_err_eol_early        = err_q[0];
  assign sts_err_eol_late         = err_q[1];
  assign sts_err_sof_early        = err_q[2];

endmodule
